// File: rtl/sd_cmd_responder_pkg.sv
// Shared definitions for the SD CMD-line responder: FSM states, frame lengths,
// response type codes and the CRC7 generator polynomial.
package sd_cmd_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RCV_CMD,
        ST_WAIT_USER,
        ST_NCR_GAP,
        ST_SEND_RESP,
        ST_SEND_CRC,
        ST_SEND_END
    } state_t;

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_SHORT = 2'd1,
        RESP_LONG  = 2'd2,
        RESP_RSVD  = 2'd3
    } resp_type_t;

    localparam logic [7:0] CRC7_BITS        = 8'd7;
    localparam logic [7:0] CMD_FRAME_BITS   = 8'd46;
    localparam logic [7:0] CMD_CRC_FIRST    = CMD_FRAME_BITS - CRC7_BITS - 8'd1;
    localparam logic [7:0] SHORT_FRAME_BITS = 8'd48;
    localparam logic [7:0] LONG_FRAME_BITS  = 8'd136;
    // Bits sent ahead of the CRC field, start bit included
    localparam logic [7:0] SHORT_DATA_BITS  = SHORT_FRAME_BITS - CRC7_BITS - 8'd1;
    localparam logic [7:0] LONG_DATA_BITS   = LONG_FRAME_BITS - CRC7_BITS - 8'd1;
    localparam logic [7:0] LONG_CRC_FIRST   = 8'd8;

    localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_cmd_responder_if.sv
// User-side bus of the SD CMD responder: decoded command out, response request in.
interface sd_cmd_responder_if;

    logic [5:0]   ocmd_index;
    logic [31:0]  ocmd_arg;
    logic         ocmd_valid;
    logic         ocrc_err;
    logic         iresp_valid;
    logic [1:0]   iresp_type;
    logic [37:0]  iresp_arg;
    logic [119:0] iresp_long;
    logic         obusy;
    logic         odone;

    modport slave (
        input  iresp_valid, iresp_type, iresp_arg, iresp_long,
        output ocmd_index, ocmd_arg, ocmd_valid, ocrc_err, obusy, odone
    );

    modport master (
        output iresp_valid, iresp_type, iresp_arg, iresp_long,
        input  ocmd_index, ocmd_arg, ocmd_valid, ocrc_err, obusy, odone
    );

endinterface

// File: rtl/sd_cmd_responder_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, with synchronous clear and enable.
module sd_crc7_gen
    import sd_cmd_responder_pkg::*;
(
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       iclr,
    input  logic       ien,
    input  logic       idin,
    output logic [6:0] ocrc
);

    logic feedback;

    assign feedback = idin ^ ocrc[6];

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ocrc <= '0;
        end else if (iclr) begin
            ocrc <= '0;
        end else if (ien) begin
            ocrc <= {ocrc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_responder.sv
// SD card CMD-line responder: decodes host commands, checks CRC7, sends responses.
// Define SD_CMD_RESP_LONG_EN to enable 136-bit responses; otherwise type 2 acts as type 0.
module sd_cmd_responder
    import sd_cmd_responder_pkg::*;
#(
    parameter int NCR = 2
)
(
    input  logic              iclk,
    input  logic              irst_n,
    inout  wire               iocmd_sd,
    sd_cmd_responder_if.slave bus
);

    localparam logic [7:0] NCR_LAST = 8'(NCR - 1);

    state_t       state_q, state_d;
    logic         ready_q;
    logic         start_armed_q, start_armed_d;
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic [37:0]  rx_shift_q, rx_shift_d;
    logic [6:0]   rx_crc_q, rx_crc_d;
    logic [127:0] tx_shift_q, tx_shift_d;
    logic         rsp_long_q, rsp_long_d;
    logic         cmd_oe_q, cmd_oe_d;
    logic         cmd_dat_q, cmd_dat_d;
    logic [5:0]   cmd_index_q, cmd_index_d;
    logic [31:0]  cmd_arg_q, cmd_arg_d;
    logic         cmd_valid_q, cmd_valid_d;
    logic         crc_err_q, crc_err_d;
    logic         done_q, done_d;

    logic         crc_clr, crc_en, crc_din;
    logic [6:0]   crc_val;
    logic         cmd_in;
    logic [7:0]   data_bits;
    resp_type_t   resp_sel;

    assign cmd_in    = iocmd_sd;
    assign iocmd_sd  = cmd_oe_q ? cmd_dat_q : 1'bz;
    assign data_bits = rsp_long_q ? LONG_DATA_BITS : SHORT_DATA_BITS;

`ifdef SD_CMD_RESP_LONG_EN
    assign resp_sel = resp_type_t'(bus.iresp_type);
`else
    assign resp_sel = (bus.iresp_type == RESP_LONG) ? RESP_NONE : resp_type_t'(bus.iresp_type);
`endif

    assign bus.ocmd_index = cmd_index_q;
    assign bus.ocmd_arg   = cmd_arg_q;
    assign bus.ocmd_valid = cmd_valid_q;
    assign bus.ocrc_err   = crc_err_q;
    assign bus.odone      = done_q;
    assign bus.obusy      = (state_q != ST_IDLE);

    // One CRC engine serves both directions; it is cleared whenever the FSM is idle or waiting
    sd_crc7_gen u_crc7 (
        .iclk   (iclk),
        .irst_n (irst_n),
        .iclr   (crc_clr),
        .ien    (crc_en),
        .idin   (crc_din),
        .ocrc   (crc_val)
    );

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b0;
            start_armed_q <= 1'b0;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            rx_crc_q      <= '0;
            tx_shift_q    <= '0;
            rsp_long_q    <= 1'b0;
            cmd_oe_q      <= 1'b0;
            cmd_dat_q     <= 1'b0;
            cmd_index_q   <= '0;
            cmd_arg_q     <= '0;
            cmd_valid_q   <= 1'b0;
            crc_err_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_q       <= 1'b1;
            start_armed_q <= start_armed_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_crc_q      <= rx_crc_d;
            tx_shift_q    <= tx_shift_d;
            rsp_long_q    <= rsp_long_d;
            cmd_oe_q      <= cmd_oe_d;
            cmd_dat_q     <= cmd_dat_d;
            cmd_index_q   <= cmd_index_d;
            cmd_arg_q     <= cmd_arg_d;
            cmd_valid_q   <= cmd_valid_d;
            crc_err_q     <= crc_err_d;
            done_q        <= done_d;
        end
    end

    // The registered drive bit is what the line shows while the FSM sits in the matching state
    always_comb begin
        state_d       = state_q;
        start_armed_d = 1'b0;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        rx_crc_d      = rx_crc_q;
        tx_shift_d    = tx_shift_q;
        rsp_long_d    = rsp_long_q;
        cmd_oe_d      = 1'b0;
        cmd_dat_d     = 1'b0;
        cmd_index_d   = cmd_index_q;
        cmd_arg_d     = cmd_arg_q;
        cmd_valid_d   = 1'b0;
        crc_err_d     = 1'b0;
        done_d        = 1'b0;
        crc_clr       = 1'b0;
        crc_en        = 1'b0;
        crc_din       = cmd_in;

        case (state_q)
            ST_IDLE: begin
                crc_clr   = 1'b1;
                bit_cnt_d = '0;
                if (start_armed_q) begin
                    // A zero start bit leaves a cleared CRC unchanged, so only the direction bit is fed
                    if (cmd_in) begin
                        crc_clr = 1'b0;
                        crc_en  = 1'b1;
                        state_d = ST_RCV_CMD;
                    end
                end else if (ready_q && !cmd_in) begin
                    start_armed_d = 1'b1;
                end
            end

            ST_RCV_CMD: begin
                bit_cnt_d = bit_cnt_q + 8'd1;
                if (bit_cnt_q < CMD_CRC_FIRST) begin
                    rx_shift_d = {rx_shift_q[36:0], cmd_in};
                    crc_en     = 1'b1;
                end else if (bit_cnt_q < CMD_FRAME_BITS - 8'd1) begin
                    rx_crc_d = {rx_crc_q[5:0], cmd_in};
                end else begin
                    bit_cnt_d = '0;
                    if (cmd_in && (rx_crc_q == crc_val)) begin
                        cmd_valid_d = 1'b1;
                        cmd_index_d = rx_shift_q[37:32];
                        cmd_arg_d   = rx_shift_q[31:0];
                        state_d     = ST_WAIT_USER;
                    end else begin
                        crc_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end

            ST_WAIT_USER: begin
                crc_clr   = 1'b1;
                bit_cnt_d = '0;
                if (bus.iresp_valid) begin
                    case (resp_sel)
                        RESP_SHORT: begin
                            tx_shift_d = {2'b00, bus.iresp_arg, 88'd0};
                            rsp_long_d = 1'b0;
                            state_d    = ST_NCR_GAP;
                        end
                        RESP_LONG: begin
                            tx_shift_d = {2'b00, 6'h3F, bus.iresp_long};
                            rsp_long_d = 1'b1;
                            state_d    = ST_NCR_GAP;
                        end
                        default: begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            ST_NCR_GAP: begin
                bit_cnt_d = bit_cnt_q + 8'd1;
                if (bit_cnt_q == NCR_LAST) begin
                    cmd_oe_d   = 1'b1;
                    cmd_dat_d  = tx_shift_q[127];
                    tx_shift_d = tx_shift_q << 1;
                    crc_din    = tx_shift_q[127];
                    crc_en     = !rsp_long_q;
                    bit_cnt_d  = 8'd1;
                    state_d    = ST_SEND_RESP;
                end
            end

            ST_SEND_RESP: begin
                cmd_oe_d = 1'b1;
                if (bit_cnt_q < data_bits) begin
                    cmd_dat_d  = tx_shift_q[127];
                    tx_shift_d = tx_shift_q << 1;
                    crc_din    = tx_shift_q[127];
                    crc_en     = !rsp_long_q || (bit_cnt_q >= LONG_CRC_FIRST);
                    bit_cnt_d  = bit_cnt_q + 8'd1;
                end else begin
                    cmd_dat_d = crc_val[6];
                    bit_cnt_d = 8'd1;
                    state_d   = ST_SEND_CRC;
                end
            end

            ST_SEND_CRC: begin
                cmd_oe_d = 1'b1;
                if (bit_cnt_q < CRC7_BITS) begin
                    cmd_dat_d = crc_val[3'd6 - bit_cnt_q[2:0]];
                    bit_cnt_d = bit_cnt_q + 8'd1;
                end else begin
                    cmd_dat_d = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_SEND_END;
                end
            end

            ST_SEND_END: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/sd_cmd_responder.md
SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

Interface
REQ-001 Parameter NCR, default 2, range 2..63: iclk cycles of released CMD line between command end bit and response start bit, counted from iresp_valid acceptance.
REQ-002 iclk  input  1  SD clock; all logic on rising edge; CMD sampled and driven on this edge.
REQ-003 irst_n  input  1  asynchronous active-low reset.
REQ-004 iocmd_sd  inout  1  CMD line; driven only while transmitting a response, otherwise high-Z.
REQ-005 ocmd_index  output  6  index of last valid command.
REQ-006 ocmd_arg  output  32  argument of last valid command.
REQ-007 ocmd_valid  output  1  one-cycle pulse: command received, CRC and end bit correct.
REQ-008 ocrc_err  output  1  one-cycle pulse: CRC7 mismatch or end bit 0.
REQ-009 iresp_valid  input  1  response request; accepted only in WAIT_USER.
REQ-010 iresp_type  input  2  0 none, 1 short (48-bit), 2 long (136-bit), 3 treated as 0.
REQ-011 iresp_arg  input  38  short payload: {index[5:0], status[31:0]}.
REQ-012 iresp_long  input  120  long payload, MSB first.
REQ-013 obusy  output  1  high in every state except IDLE.
REQ-014 odone  output  1  one-cycle pulse after response end bit driven, or on acceptance of type 0/3.

Function
REQ-015 States: IDLE, RCV_CMD, WAIT_USER, NCR_GAP, SEND_RESP, SEND_CRC, SEND_END.
REQ-016 IDLE: sampled 0 arms start; next bit 1 (host direction) enters RCV_CMD; next bit 0 returns to IDLE without outputs.
REQ-017 RCV_CMD shifts 46 bits: index 6, arg 32, CRC7 7, end 1; CRC7 (x^7+x^3+1) computed over start, direction, index, arg.
REQ-018 Cycle after end bit sampled: ocmd_valid pulses with ocmd_index/ocmd_arg updated same cycle, state WAIT_USER; on error ocrc_err pulses, index/arg held, state IDLE.
REQ-019 WAIT_USER waits indefinitely; iresp_valid latches type and payload; type 0/3 -> odone, IDLE; type 1/2 -> NCR_GAP.
REQ-020 NCR_GAP keeps line high-Z exactly NCR cycles, then SEND_RESP.
REQ-021 Short frame: 0, 0, iresp_arg[37:0], CRC7 over those 40 bits, 1; 48 cycles total.
REQ-022 Long frame: 0, 0, 6'b111111, iresp_long[119:0], CRC7 over the 120 payload bits only, 1; 136 cycles total.
REQ-023 SEND_END drives 1 for one cycle, releases line next cycle with odone pulse, IDLE.
REQ-024 iresp_valid outside WAIT_USER ignored; CMD activity outside IDLE/RCV_CMD ignored.
REQ-025 Driven bit and output-enable registered; no combinational path from inputs to iocmd_sd.

Reset
REQ-026 irst_n low: immediately release iocmd_sd, state IDLE, all outputs 0, counters and CRC cleared, including mid-frame.
REQ-027 First start detection possible on the second iclk edge after irst_n deasserts.

Configuration
REQ-028 Macro SD_CMD_RESP_LONG_EN: defined -> long responses per REQ-022; undefined -> iresp_type 2 treated as 0, iresp_long ignored, port widths unchanged.

Structure
REQ-029 Shared package holds state encoding, frame lengths (48, 136, 46), response-type codes, CRC7 polynomial.
REQ-030 One sub-module sd_crc7_gen: serial CRC7 with synchronous clear, enable, 7-bit parallel output; instanced once, shared between receive and transmit.

Verification
REQ-031 CMD0 frame 0x40_00000000 CRC 0x4A end 1 -> ocmd_valid, index 0, arg 0x00000000.
REQ-032 CMD8 frame 0x48_000001AA CRC 0x43, reply type 1 iresp_arg {8,0x000001AA}, NCR 2 -> line exact 0x08000001AA13 after 2 released cycles, then odone.
REQ-033 CMD17 arg 0 with CRC 0x2B (expected 0x2A) -> ocrc_err pulse, no ocmd_valid, line never driven.
REQ-034 CMD2 reply type 2, iresp_long 120'h1 -> 136-bit frame, header 0x3F, CRC over payload; with macro undefined -> immediate odone, no drive.
REQ-035 irst_n low at bit 20 of short response -> line high-Z same cycle, obusy 0; subsequent CMD0 decoded correctly.
REQ-036 Start bit followed by direction 0 (card-style frame) -> no outputs, stays IDLE.
